uart_rx_word: RTL and testbench



---
 rtl/uart_rx_word_if.sv | 22 ++
 rtl/uart_rx_word.sv | 276 +++++++++++++++++++++++++++
 tb/tb_uart_rx_word.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_word_if.sv
// CPU read-side bus of the UART receive path: read strobe, byte address,
// combinational read data and the "word available" flag.
interface uart_rx_word_if;
  logic        re;
  logic [31:0] address;
  logic [31:0] dataOut;
  logic        word_valid;

  modport master (
    output re,
    output address,
    input  dataOut,
    input  word_valid
  );

  modport slave (
    input  re,
    input  address,
    output dataOut,
    output word_valid
  );
endinterface

// File: rtl/uart_rx_word.sv
// UART 8N1 receiver that packs four bytes per 32-bit word (first byte in
// [31:24]), queues finished words in a small FIFO and exposes the FIFO head
// and a status word as memory-mapped reads.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | line idle, waiting for a falling edge on rxs
// S_START     | half-bit wait, then confirm the start bit (else glitch)
// S_DATA      | eight full-bit waits, sampling data bits LSB first
// S_STOP      | full-bit wait, then check the stop bit
// S_WAIT_HIGH | framing error seen, waiting for the line to return high
module uart_rx_word #(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] ADDR_DATA    = 32'h0000_7004,
  parameter logic [31:0] ADDR_STAT    = 32'h0000_7008
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    rx,
  uart_rx_word_if.slave bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   FCNT_ONE  = (PTR_W + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  // synchroniser and edge history
  logic rx_meta;
  logic rxs;
  logic rxs_d;

  // receive FSM
  state_t           state;
  state_t           state_d;
  logic [CNT_W-1:0] baud_cnt;
  logic [CNT_W-1:0] baud_cnt_d;
  logic             baud_tc;
  logic [2:0]       bit_cnt;
  logic [2:0]       bit_cnt_d;
  logic [7:0]       shift;
  logic [7:0]       shift_d;
  logic             byte_ok;
  logic             frame_set;

  // word packing
  logic        byte_valid_q;
  logic [1:0]  byte_idx;
  logic [31:0] word_q;
  logic        push_req;

  // FIFO
  logic [31:0]    mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_d;
  logic             word_valid_q;
  logic             full;
  logic             pop;
  logic             push_ok;
  logic             overrun_set;
  logic             stat_rd;

  // sticky error flags
  logic overrun;
  logic frame_err;

  // Two-stage synchroniser on the async line; the third stage gives the
  // previous synchronised value so IDLE reacts to a falling edge only, which
  // keeps a reset released mid-frame from locking onto a data bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
    end
  end

  // FSM state and bit-timing registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_cnt_d;
      bit_cnt  <= bit_cnt_d;
      shift    <= shift_d;
    end
  end

  // FSM next state; baud_cnt is a down-counter sampled at terminal count
  always_comb begin
    state_d    = state;
    baud_cnt_d = baud_cnt;
    bit_cnt_d  = bit_cnt;
    shift_d    = shift;
    byte_ok    = 1'b0;
    frame_set  = 1'b0;
    baud_tc    = (baud_cnt == '0);
    case (state)
      S_IDLE: begin
        if (rxs_d && !rxs) begin
          baud_cnt_d = HALF_LOAD;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (baud_tc) begin
          if (rxs) begin
            state_d = S_IDLE;
          end else begin
            baud_cnt_d = BIT_LOAD;
            bit_cnt_d  = '0;
            state_d    = S_DATA;
          end
        end else begin
          baud_cnt_d = baud_cnt - CNT_ONE;
        end
      end
      S_DATA: begin
        if (baud_tc) begin
          shift_d    = {rxs, shift[7:1]};
          baud_cnt_d = BIT_LOAD;
          if (bit_cnt == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_cnt_d = bit_cnt + 3'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt - CNT_ONE;
        end
      end
      S_STOP: begin
        if (baud_tc) begin
          if (rxs) begin
            byte_ok = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_set = 1'b1;
            state_d   = S_WAIT_HIGH;
          end
        end else begin
          baud_cnt_d = baud_cnt - CNT_ONE;
        end
      end
      S_WAIT_HIGH: begin
        if (rxs) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Byte packing: a good byte lands in its slot the cycle after the stop
  // sample; the fourth byte raises a one-cycle push request for the cycle
  // after that, so the FIFO always sees a fully assembled word.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_valid_q <= 1'b0;
      byte_idx     <= 2'd0;
      word_q       <= '0;
      push_req     <= 1'b0;
    end else begin
      byte_valid_q <= byte_ok;
      push_req     <= 1'b0;
      if (byte_valid_q) begin
        case (byte_idx)
          2'd0:    word_q[31:24] <= shift;
          2'd1:    word_q[23:16] <= shift;
          2'd2:    word_q[15:8]  <= shift;
          default: word_q[7:0]   <= shift;
        endcase
        byte_idx <= byte_idx + 2'd1;
        push_req <= (byte_idx == 2'd3);
      end
    end
  end

  // Push/pop qualification; a pop in the same cycle makes room in a full FIFO
  always_comb begin
    full        = (count == CNT_FULL);
    pop         = bus.re && (bus.address == ADDR_DATA) && word_valid_q;
    stat_rd     = bus.re && (bus.address == ADDR_STAT);
    push_ok     = push_req && (!full || pop);
    overrun_set = push_req && full && !pop;
    count_d     = count;
    case ({push_ok, pop})
      2'b10:   count_d = count + FCNT_ONE;
      2'b01:   count_d = count - FCNT_ONE;
      default: count_d = count;
    endcase
  end

  // FIFO pointers, occupancy and the registered non-empty flag
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      word_valid_q <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count        <= count_d;
      word_valid_q <= (count_d != '0);
    end
  end

  // FIFO storage; contents need no reset since reads are gated by word_valid
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= word_q;
    end
  end

  // Sticky error flags; a new error in the same cycle as a status read wins
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (overrun_set) begin
        overrun <= 1'b1;
      end else if (stat_rd) begin
        overrun <= 1'b0;
      end
      if (frame_set) begin
        frame_err <= 1'b1;
      end else if (stat_rd) begin
        frame_err <= 1'b0;
      end
    end
  end

  // Read-data mux, combinational from the address
  always_comb begin
    bus.dataOut = '0;
    if (bus.address == ADDR_DATA) begin
      bus.dataOut = word_valid_q ? mem[rd_ptr] : '0;
    end else if (bus.address == ADDR_STAT) begin
      bus.dataOut = {24'b0, byte_idx, 2'b00, overrun, frame_err, full, word_valid_q};
    end
  end

  assign bus.word_valid = word_valid_q;

endmodule

// File: tb/tb_uart_rx_word.sv
// Directed bench for uart_rx_word: stimulus drives the serial line and CPU
// reads and queues the expected read data; a negedge monitor pops and
// compares on every read and checks the word_valid rise cycle when asked.
module tb_uart_rx_word;

  localparam int          CPB    = 16;
  localparam int          DEPTH  = 8;
  localparam logic [31:0] A_DATA = 32'h0000_7004;
  localparam logic [31:0] A_STAT = 32'h0000_7008;
  // start bit driven after posedge k: rx_meta at k+1, rxs at k+2, FSM leaves
  // IDLE at k+3; stop sample half a bit plus nine bits later; then pack,
  // then push with word_valid registered alongside.
  localparam int LAT = 3 + CPB / 2 + 9 * CPB + 2;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic rx;
  uart_rx_word_if bus ();

  uart_rx_word #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .ADDR_DATA   (A_DATA),
    .ADDR_STAT   (A_STAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .rx   (rx),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t        exp_q[$];
  int          rise_q[$];
  int          n_pass   = 0;
  int          n_checks = 0;
  bit          done     = 1'b0;
  logic        wv_prev  = 1'b0;
  logic [31:0] w10;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %08h, expected %08h", nm, act, req);
  endfunction

  function automatic logic [31:0] word_of(input int n);
    logic [7:0] b;
    b = 8'(n);
    return {8'h10 + b, 8'h20 + b, 8'h30 + b, 8'h40 + b};
  endfunction

  // Monitor: scoreboard for reads, word_valid rise timing, end-of-run summary
  always @(negedge clk) begin
    #1;
    if (bus.word_valid && !wv_prev && rise_q.size() > 0) begin
      chk("word_valid_rise_cycle", 32'(cyc), 32'(rise_q.pop_front()));
    end
    wv_prev = bus.word_valid;
    if (bus.re) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_read: addr %08h data %08h, no expectation queued",
                 bus.address, bus.dataOut);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk(e.name, bus.dataOut, e.val);
      end
    end
    if (done) begin
      chk("pending_reads", 32'(exp_q.size()), 32'd0);
      chk("pending_rises", 32'(rise_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    if (!stop) repeat (CPB) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] v, input string nm);
    exp_t e;
    e.name = nm;
    e.val  = v;
    exp_q.push_back(e);
    bus.re      = 1'b1;
    bus.address = a;
    @(negedge clk);
    bus.re      = 1'b0;
    bus.address = '0;
  endtask

  task automatic wait_wv(input int max_cycles);
    for (int i = 0; i < max_cycles && !bus.word_valid; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset       = 1'b1;
    rx          = 1'b1;
    bus.re      = 1'b0;
    bus.address = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // reset state: every address reads zero
    rd(A_STAT, 32'h0, "reset_stat");
    rd(A_DATA, 32'h0, "reset_data");
    rd(32'h0000_7000, 32'h0, "reset_tx_addr");
    rd(32'h0000_700C, 32'h0, "reset_other_addr");

    // basic word with latency check
    send_byte(8'hDE, 1'b1);
    send_byte(8'hAD, 1'b1);
    send_byte(8'hBE, 1'b1);
    rise_q.push_back(cyc + LAT);
    send_byte(8'hEF, 1'b1);
    wait_wv(4 * CPB);
    rd(A_DATA, 32'hDEAD_BEEF, "basic_word");
    rd(A_STAT, 32'h0, "basic_empty_after_pop");

    // glitch rejection
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    rd(A_STAT, 32'h0, "glitch_stat");
    rd(A_DATA, 32'h0, "glitch_data");

    // framing error with one byte already packed
    send_byte(8'h11, 1'b1);
    send_byte(8'h55, 1'b0);
    rd(A_STAT, 32'h44, "frame_stat");
    rd(A_STAT, 32'h40, "frame_cleared");
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    wait_wv(4 * CPB);
    rd(A_DATA, 32'h1122_3344, "frame_word");
    rd(A_STAT, 32'h0, "frame_after");

    // reset with a partial word
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    do_reset();
    rd(A_STAT, 32'h0, "midreset_stat");
    send_word(32'h0102_0304);
    wait_wv(4 * CPB);
    rd(A_DATA, 32'h0102_0304, "midreset_word");
    rd(A_DATA, 32'h0, "midreset_no_stale");

    // overrun: nine words into an eight-deep FIFO
    for (int n = 1; n <= 9; n++) send_word(word_of(n));
    rd(A_STAT, 32'h0B, "overrun_stat");
    rd(A_STAT, 32'h03, "overrun_cleared");

    // full boundary: pop in the same cycle as the push of word 10
    w10 = word_of(10);
    send_byte(w10[31:24], 1'b1);
    send_byte(w10[23:16], 1'b1);
    send_byte(w10[15:8], 1'b1);
    fork
      send_byte(w10[7:0], 1'b1);
      begin
        repeat (LAT - 1) @(negedge clk);
        rd(A_DATA, word_of(1), "boundary_pop_w1");
      end
    join
    rd(A_STAT, 32'h03, "boundary_stat");
    for (int n = 2; n <= 8; n++) rd(A_DATA, word_of(n), $sformatf("drain_w%0d", n));
    rd(A_DATA, w10, "drain_w10");
    rd(A_DATA, 32'h0, "drain_empty");
    rd(A_STAT, 32'h0, "final_stat");

    done = 1'b1;
    repeat (5) @(negedge clk);
    $display("FAIL end_of_run: monitor did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "monitor did not finish");
  end

endmodule
